// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encodings, word width, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_responder_pkg;

    // Word width of the storage array and data ports
    localparam int MEM_WORD_W = 32;

    // Width of the latency down-counter (covers LATENCY up to 15)
    localparam int MEM_CNT_W = 4;

    // Responder FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

endpackage : mem_responder_pkg

// File: rtl/mem_latency_counter.sv
// Loadable down-counter with a zero flag; times the BUSY phase of the responder.
// Latency: load/decrement take effect at the next rising edge; zero flag is combinational from the count.
// Backpressure: none; the caller decides when to load or decrement.
module mem_latency_counter
    import mem_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [MEM_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [MEM_CNT_W-1:0] cnt_q;
    logic [MEM_CNT_W-1:0] cnt_d;

    // Next count: a load wins over a decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : mem_latency_counter

// File: rtl/mem_responder.sv
// Multi-cycle data/instruction memory answering one CPU request at a time; optional byte strobes via MEM_WSTRB_EN.
// Latency: dout_valid is seen in the LATENCY-th cycle after the accept edge; one request per LATENCY+1 cycles.
// Backpressure: mem_ready is low from acceptance through the response cycle; inputs are ignored while busy.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_WORD_W-1:0] addr,
    input  logic [MEM_WORD_W-1:0] din,
`ifdef MEM_WSTRB_EN
    input  logic [3:0]            mem_wstrb,
`endif
    output logic                  mem_ready,
    output logic [MEM_WORD_W-1:0] dout,
    output logic                  dout_valid,
    output logic                  mem_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // BUSY lasts LATENCY-1 cycles: load LATENCY-2 and leave when the count reaches zero
    localparam logic [MEM_CNT_W-1:0] LOAD_VAL = (LATENCY > 1) ? MEM_CNT_W'(LATENCY - 2) : '0;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..15");
    end

    mem_state_e state_q;
    mem_state_e state_d;

    // Holds mem_ready low until the first edge after reset release
    logic init_q;

    // Request captured at acceptance
    logic                  rd_q;
    logic                  wr_q;
    logic [MEM_WORD_W-1:0] addr_q;
    logic [MEM_WORD_W-1:0] din_q;
`ifdef MEM_WSTRB_EN
    logic [3:0]            wstrb_q;
`endif

    logic [MEM_WORD_W-1:0] dout_q;
    logic                  err_q;

    // Storage array; deliberately not reset so contents survive a reset
    logic [MEM_WORD_W-1:0] mem_q [DEPTH];

    // FSM control
    logic accept;
    logic in_idle;
    logic enter_resp;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    // Request seen by the access logic: live inputs when accepting, latched copy otherwise
    logic                  cur_rd;
    logic                  cur_wr;
    logic [MEM_WORD_W-1:0] cur_addr;
    logic [MEM_WORD_W-1:0] cur_din;
    logic [3:0]            cur_wstrb;

    // Request decode
    logic          both_err;
    logic          misal_err;
    logic          range_err;
    logic          req_err;
    logic [AW-1:0] widx;
    logic          do_write;
    logic          do_read;

    mem_latency_counter u_lat_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign in_idle = (state_q == MEM_IDLE);
    assign accept  = mem_ready && (mem_read || mem_write);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MEM_IDLE: begin
                if (accept) begin
                    state_d = (LATENCY == 1) ? MEM_RESP : MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                if (cnt_zero) begin
                    state_d = MEM_RESP;
                end
            end
            MEM_RESP: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    // FSM outputs and counter control
    always_comb begin
        mem_ready  = in_idle && init_q;
        dout_valid = (state_q == MEM_RESP);
        cnt_load   = accept;
        cnt_dec    = (state_q == MEM_BUSY) && !cnt_zero;
        enter_resp = ((state_q == MEM_BUSY) && cnt_zero) || (accept && (LATENCY == 1));
    end

    // Select the live request at acceptance (only matters for LATENCY==1) or the latched one
    always_comb begin
        cur_rd   = in_idle ? mem_read  : rd_q;
        cur_wr   = in_idle ? mem_write : wr_q;
        cur_addr = in_idle ? addr      : addr_q;
        cur_din  = in_idle ? din       : din_q;
`ifdef MEM_WSTRB_EN
        cur_wstrb = in_idle ? mem_wstrb : wstrb_q;
`else
        cur_wstrb = 4'hF;
`endif
    end

    // Error decode; the index is range-checked at full width before truncation
    always_comb begin
        both_err  = cur_rd && cur_wr;
        misal_err = (cur_addr[1:0] != 2'b00);
        range_err = ({2'b00, cur_addr[MEM_WORD_W-1:2]} >= MEM_WORD_W'(DEPTH));
        req_err   = both_err || misal_err || range_err;
        widx      = cur_addr[AW+1:2];
        do_write  = enter_resp && cur_wr && !req_err;
        do_read   = enter_resp && cur_rd && !cur_wr;
    end

    // Startup flag: mem_ready appears one edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    // Capture the request at the accept edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
`ifdef MEM_WSTRB_EN
            wstrb_q <= '0;
`endif
        end else if (accept) begin
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            addr_q  <= addr;
            din_q   <= din;
`ifdef MEM_WSTRB_EN
            wstrb_q <= mem_wstrb;
`endif
        end
    end

    // Response data and error flag, updated on entry to RESP; writes leave dout untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
            err_q  <= 1'b0;
        end else if (enter_resp) begin
            err_q <= req_err;
            if (do_read) begin
                dout_q <= (misal_err || range_err) ? '0 : mem_q[widx];
            end
        end
    end

    // Array write on entry to RESP, byte-masked by the strobes
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_wstrb[b]) begin
                    mem_q[widx][8*b +: 8] <= cur_din[8*b +: 8];
                end
            end
        end
    end

    assign dout    = dout_q;
    assign mem_err = err_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a response scoreboard and a small memory model.
// Latency: checks the response cycle against LATENCY.
// Backpressure: waits (bounded) for mem_ready before each request.
module tb_mem_responder;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] din;
`ifdef MEM_WSTRB_EN
    logic [3:0]  mem_wstrb;
`endif
    logic        mem_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        mem_err;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_dout;
    int          total = 0;
    int          bad   = 0;

    mem_responder #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .din        (din),
`ifdef MEM_WSTRB_EN
        .mem_wstrb  (mem_wstrb),
`endif
        .mem_ready  (mem_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, predict its response, and check the response timing and contents
    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] strb, input string tag);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          idx;
        logic [31:0] w;
        for (int n = 0; n < 20 && mem_ready !== 1'b1; n++) @(negedge clk);
        check({tag, "_rdy_pre"}, {31'b0, mem_ready}, 32'd1);

        idx = int'(a >> 2);
        if (rd && wr) begin
            e.e = 1'b1;
        end else if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) begin
            e.e = 1'b1;
            if (rd) exp_dout = 32'h0;
        end else if (wr) begin
            e.e = 1'b0;
            w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
`ifdef MEM_WSTRB_EN
            for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
`else
            w = d;
`endif
            ref_mem[idx] = w;
        end else begin
            e.e = 1'b0;
            exp_dout = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        end
        e.d = exp_dout;
        sb.push_back(e);

        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        din       = d;
`ifdef MEM_WSTRB_EN
        mem_wstrb = strb;
`endif
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'hFFFF_FFFF;
        din       = 32'h0BAD_0BAD;

        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (dout_valid === 1'b1) begin
                lat = c;
                break;
            end
            check({tag, "_rdy_busy"}, {31'b0, mem_ready}, 32'd0);
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
        got = sb.pop_front();
        if (lat > 0) begin
            check({tag, "_rdy_resp"}, {31'b0, mem_ready}, 32'd0);
            check({tag, "_dout"}, dout, got.d);
            check({tag, "_err"}, {31'b0, mem_err}, {31'b0, got.e});
            @(negedge clk);
            check({tag, "_vld_off"}, {31'b0, dout_valid}, 32'd0);
            check({tag, "_rdy_back"}, {31'b0, mem_ready}, 32'd1);
        end
    endtask

    initial begin
        reset     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0;
        din       = 32'h0;
`ifdef MEM_WSTRB_EN
        mem_wstrb = 4'h0;
`endif
        exp_dout  = 32'h0;

        // Reset state and release
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_dout", dout, 32'h0);
        check("rst_valid", {31'b0, dout_valid}, 32'd0);
        check("rst_err", {31'b0, mem_err}, 32'd0);
        reset = 1'b1;
        #1;
        check("rel_ready_early", {31'b0, mem_ready}, 32'd0);
        @(negedge clk);
        check("rel_ready", {31'b0, mem_ready}, 32'd1);
        check("rel_dout", dout, 32'h0);
        check("rel_valid", {31'b0, dout_valid}, 32'd0);

        // Basic write then read
        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "rd10");

        // Idle: outputs hold
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_valid", {31'b0, dout_valid}, 32'd0);
            check("idle_dout", dout, 32'hDEADBEEF);
        end

        // Both read and write: error, no access, dout holds
        req(1'b0, 1'b1, 32'h20, 32'h5A5A0020, 4'hF, "wr20");
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "rd10b");
        req(1'b1, 1'b1, 32'h20, 32'h99999999, 4'hF, "both20");
        req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, "rd20");

        // Misaligned and out-of-range accesses
        req(1'b1, 1'b0, 32'h13, 32'h0, 4'hF, "rd_misal");
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "rd10c");
        req(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, "rd_oob");
        req(1'b0, 1'b1, 32'h11, 32'h77777777, 4'hF, "wr_misal");
        req(1'b0, 1'b1, 32'(4 * DEPTH + 16), 32'h66666666, 4'hF, "wr_oob");
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "rd10d");
        req(1'b0, 1'b1, 32'(4 * DEPTH - 4), 32'h0123ABCD, 4'hF, "wr_last");
        req(1'b1, 1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'hF, "rd_last");
        req(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, "rd0");

        // Reset during BUSY abandons the write
        req(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, "wr40");
        check("rb_rdy", {31'b0, mem_ready}, 32'd1);
        mem_write = 1'b1;
        addr      = 32'h40;
        din       = 32'h12345678;
`ifdef MEM_WSTRB_EN
        mem_wstrb = 4'hF;
`endif
        @(negedge clk);
        mem_write = 1'b0;
        check("rb_busy_rdy", {31'b0, mem_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("rb_rst_rdy", {31'b0, mem_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rb_no_valid", {31'b0, dout_valid}, 32'd0);
        end
        reset    = 1'b1;
        exp_dout = 32'h0;
        @(negedge clk);
        check("rb_rel_rdy", {31'b0, mem_ready}, 32'd1);
        check("rb_rel_dout", dout, 32'h0);
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, "rd40");

`ifdef MEM_WSTRB_EN
        // Byte strobes
        req(1'b0, 1'b1, 32'h80, 32'h11223344, 4'hF, "wr80");
        req(1'b0, 1'b1, 32'h80, 32'hAABBCCDD, 4'b0101, "wr80_strb");
        req(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, "rd80");
        check("strb_value", dout, 32'h11BB33DD);
        req(1'b0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'b0000, "wr80_nop");
        req(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, "rd80b");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_responder
